poly_unit_core: RTL and testbench
=================================

// Module: poly_unit_core
// PURPOSE
//  Polynomial storage/transfer core of the Kyber90s accelerator. Holds one 128-coefficient
//  polynomial: 32 words, each packing 4 x 12-bit coefficients. Three operations:
//   - load words from an external source,
//   - stream the words back out,
//   - accept the NTT/INTT mode codes as reserved no-ops in this revision.
//  Started by a one-cycle run pulse plus a 2-bit mode code; completion is signalled by a done pulse.
// PARAMETERS
//  WID    12   coefficient width in bits
//  CPW    4    coefficients per memory word; word width DW = WID*CPW = 48
//  AW     5    word address width; depth = 2**AW = 32 words
// PORTS
//  clk           in   1    single clock; all state updates on the rising edge
//  rst           in   1    asynchronous, active-low reset
//  data_in       in   DW   word to store (coefficient i at bits [WID*i+WID-1 : WID*i])
//  data_in_add   in   AW   word address for data_in
//  data_in_done  in   1    level; high ends a load
//  data_out      out  DW   registered read-out word
//  mode          in   2    0=NTT, 1=INTT, 2=DATAIN, 3=DATAOUT; sampled only with run
//  run           in   1    one-cycle start strobe
//  done          out  1    one-cycle completion pulse
// BEHAVIOUR
//  Reset (rst=0, any time, asynchronous):
//   - state=IDLE, done=0, data_out=0, read counter=0.
//   - RAM contents are not reset.
//   - A reset mid-operation aborts it; no done pulse is issued.
//  States: IDLE, LOAD, DUMP, NOP.
//   - Leaving IDLE: at a rising edge with run=1 -> LOAD (mode 2), DUMP (mode 3), NOP (mode 0/1).
//   - run is ignored outside IDLE. mode is don't-care while run=0.
//  LOAD:
//   - Every cycle with data_in_done=0: RAM[data_in_add] <= data_in. Writes land in order; the last
//     write to an address wins, and addresses may wrap or repeat.
//   - Cycle with data_in_done=1: no write, state -> IDLE, done=1 for that one cycle.
//   - If data_in_done is already high on the first LOAD cycle, the load completes with zero writes.
//  DUMP:
//   - Counter k runs 0..31. RAM[k] is registered onto data_out at the edge k+1 after the run edge,
//     so words appear on 32 consecutive cycles.
//   - done=1 for exactly the one cycle in which word 31 is on data_out; state -> IDLE at that same edge.
//   - data_out holds word 31 afterwards, until the next DUMP or reset.
//  NOP (NTT/INTT reserved): one cycle, done=1, RAM and data_out unchanged, -> IDLE.
//  done is a registered output: 0 in IDLE except the single completion cycle.
//  Memory:
//   - 32 x DW synchronous-write register array.
//   - Read via the registered data_out only; there is no combinational path from inputs to outputs.
//  Arithmetic: the address counter is AW bits wide; no modular coefficient arithmetic in this revision.
// TESTING
//  Bench source: a 32 x 48 ROM (synchronous read) holding word k = {4{12'(k+1)}}, addressed by a
//  counter; data_in_add = counter-1 so address and data are aligned.
//  1 Reset: hold rst=0 10 cycles -> data_out=0, done=0; release; idle 5 cycles -> done stays 0.
//  2 Load: run=1,mode=2 one cycle; stream 34 writes (addresses 31,0..31,0), then data_in_done=1
//    -> done pulses exactly once, one cycle, RAM[k]={4{12'(k+1)}}.
//  3 Dump: run=1,mode=3 one cycle -> data_out shows word 0..31 on 32 consecutive cycles,
//    done=1 only with word 31 (0x020020020020), data_out then holds that value.
//  4 Reserved: run with mode=0 and with mode=1 -> done one cycle later, one cycle wide;
//    a following dump shows unchanged RAM.
//  5 Busy/ignore: pulse run,mode=0 mid-dump -> dump unaffected, single done;
//    load started with data_in_done already 1 -> immediate done, no RAM change.
//  6 Async reset mid-dump at word 10 -> data_out=0 and done=0 immediately (no clock edge),
//    no done pulse; a new dump restarts from word 0.

Source files
------------

// File: rtl/poly_unit_core.sv
// Polynomial storage/transfer core: one 128-coefficient polynomial held as 32 words of 4 x 12-bit coefficients.
// Loads words from an external source, streams them back out, and treats the NTT/INTT codes as reserved no-ops.
module poly_unit_core #(
    parameter int WID = 12,
    parameter int CPW = 4,
    parameter int AW  = 5,
    localparam int DW = WID * CPW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] data_in_add,
    input  logic          data_in_done,
    output logic [DW-1:0] data_out,
    input  logic [1:0]    mode,
    input  logic          run,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, NOP} state_t;

    localparam logic [1:0] M_DATAIN  = 2'd2;
    localparam logic [1:0] M_DATAOUT = 2'd3;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done_nxt;
    logic          we;
    logic          rd_en;
    logic [DW-1:0] ram [2**AW];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        we        = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (run) begin
                    case (mode)
                        M_DATAIN:  state_nxt = LOAD;
                        M_DATAOUT: state_nxt = DUMP;
                        default:   state_nxt = NOP;
                    endcase
                end
            end
            LOAD: begin
                if (data_in_done) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    we = 1'b1;
                end
            end
            DUMP: begin
                // done rises at the same edge that puts the last word on data_out
                rd_en   = 1'b1;
                cnt_nxt = cnt + AW'(1);
                if (cnt == '1) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            NOP: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            if (rd_en) data_out <= ram[cnt];
        end
    end

    // Storage is deliberately left out of reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) ram[data_in_add] <= data_in;
    end

endmodule

// File: tb/tb_poly_unit_core.sv
// Directed bench for poly_unit_core: ROM-fed load, full dumps, reserved modes, busy-ignore and async abort.
module tb_poly_unit_core;

    localparam int WID   = 12;
    localparam int CPW   = 4;
    localparam int AW    = 5;
    localparam int DW    = WID * CPW;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in;
    logic [AW-1:0] data_in_add;
    logic          data_in_done;
    logic [DW-1:0] data_out;
    logic [1:0]    mode;
    logic          run;
    logic          done;

    always #5 clk = ~clk;

    poly_unit_core #(.WID(WID), .CPW(CPW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_add  (data_in_add),
        .data_in_done (data_in_done),
        .data_out     (data_out),
        .mode         (mode),
        .run          (run),
        .done         (done)
    );

    // Source ROM with synchronous read; address lags the counter by one so data and address line up.
    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] rom_q;
    logic [AW-1:0] rom_addr;
    always @(posedge clk) rom_q <= rom[rom_addr];
    assign data_in     = rom_q;
    assign data_in_add = rom_addr - AW'(1);

    function automatic logic [DW-1:0] word_of(input int k);
        logic [WID-1:0] c;
        c = WID'(k + 1);
        return {CPW{c}};
    endfunction

    // Model state: expected RAM image and expected outputs for the current cycle.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_dout;
    logic          exp_done;
    logic          chk_en = 1'b0;
    string         tag = "reset";
    int            n_tests = 0;
    int            n_fail  = 0;

    always begin
        @(negedge clk or negedge rst);
        #1;
        if (chk_en) begin
            n_tests++;
            if (data_out !== exp_dout) begin
                n_fail++;
                $display("FAIL %s.data_out @%0t: got %h, expected %h", tag, $time, data_out, exp_dout);
            end
            n_tests++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL %s.done @%0t: got %b, expected %b", tag, $time, done, exp_done);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal values pin a few words of the model independently of word_of().
    function automatic logic [DW-1:0] pin(input int i);
        if (i == 0)  return 48'h001001001001;
        if (i == 10) return 48'h00b00b00b00b;
        if (i == 31) return 48'h020020020020;
        return mem_m[i];
    endfunction

    task automatic do_load(input int n);
        tag = (n == 0) ? "load_empty" : "load";
        run = 1'b1; mode = 2'd2; rom_addr = AW'(31); data_in_done = (n == 0);
        step();
        run = 1'b0; mode = 2'd3;
        for (int i = 0; i < n; i++) begin
            rom_addr = AW'(i);
            data_in_done = 1'b0;
            step();
            mem_m[(i + 31) % DEPTH] = word_of((i + 31) % DEPTH);
        end
        data_in_done = 1'b1;
        step();
        exp_done = 1'b1;
        data_in_done = 1'b0;
        step();
        exp_done = 1'b0;
        step();
    endtask

    task automatic do_nop(input logic [1:0] m);
        tag = (m == 2'd0) ? "ntt" : "intt";
        run = 1'b1; mode = m;
        step();
        run = 1'b0; mode = 2'd2;
        step();
        exp_done = 1'b1;
        step();
        exp_done = 1'b0;
        step();
    endtask

    task automatic do_dump(input int abort_at, input int busy_at);
        tag = (abort_at >= 0) ? "dump_abort" : (busy_at >= 0) ? "dump_busy" : "dump";
        run = 1'b1; mode = 2'd3;
        step();
        run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == busy_at) begin
                run = 1'b1; mode = 2'd0;
            end else begin
                run = 1'b0;
            end
            step();
            exp_dout = pin(i);
            exp_done = (i == DEPTH - 1);
            if (i == abort_at) begin
                @(negedge clk);
                #2;
                rst = 1'b0;
                exp_dout = '0;
                exp_done = 1'b0;
                step();
                step();
                rst = 1'b1;
                repeat (3) step();
                return;
            end
        end
        run = 1'b0;
        step();
        exp_done = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) rom[k] = word_of(k);
        run = 1'b0; mode = 2'd0; data_in_done = 1'b0; rom_addr = '0;
        exp_dout = '0; exp_done = 1'b0;
        chk_en = 1'b1;
        #1 rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        tag = "idle";
        repeat (5) step();

        do_load(34);
        do_dump(-1, -1);
        do_nop(2'd0);
        do_nop(2'd1);
        do_dump(-1, -1);
        do_dump(-1, 5);
        do_load(0);
        do_dump(-1, -1);
        do_dump(10, -1);
        do_dump(-1, -1);

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
